fifo_wr_arbiter: RTL

//  Packet-granular round-robin arbiter sharing the async FIFO write port among N_REQ producers.

---
 rtl/fifo_wr_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Packet-granular round-robin arbiter that shares one async-FIFO write port
// among N_REQ producers. It lives in the FIFO write-clock domain. A granted
// producer owns the port for exactly PKT_LEN beats, so packets are never
// interleaved. The FIFO full flag stalls the burst without losing a beat.
//
// Optional feature macro: FIFO_ARB_STATS_EN
//   defined     -> PKT_CNT (wrapping) and STALL_CNT (saturating) are built
//   not defined -> PKT_CNT and STALL_CNT are tied to zero
//
// Ports
//   CLK        in   write-domain clock (FIFO W_CLK)
//   RST        in   asynchronous reset, active low
//   REQ        in   [N_REQ]            requester i holds a complete packet
//   REQ_DATA   in   [N_REQ*DATA_WIDTH] current beat of each requester
//   POP        out  [N_REQ]            one-hot: beat of requester i consumed
//   GNT        out  [N_REQ]            registered one-hot grant, 0 when idle
//   BUSY       out                     high while a burst is in progress
//   FULL       in                      FIFO full flag
//   W_INC      out                     FIFO write enable
//   WR_DATA    out  [DATA_WIDTH]       FIFO write data (0 outside a burst)
//   PKT_CNT    out  [16]               packets completed
//   STALL_CNT  out  [16]               burst cycles blocked by FULL
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 10
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_REQ-1:0]            REQ,
    input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [N_REQ-1:0]            POP,
    output logic [N_REQ-1:0]            GNT,
    output logic                        BUSY,
    input  logic                        FULL,
    output logic                        W_INC,
    output logic [DATA_WIDTH-1:0]       WR_DATA,
    output logic [15:0]                 PKT_CNT,
    output logic [15:0]                 STALL_CNT
);

    localparam int CNT_W = $clog2(PKT_LEN) + 1;
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   gnt, gnt_nxt;
    logic [PTR_W-1:0]   gnt_idx, gnt_idx_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic               found;
    logic [PTR_W-1:0]   sel_idx;
    logic               w_inc;
    logic               last_beat;
    logic [DATA_WIDTH-1:0] beat_data;

    // Round-robin search: first requester at or above the pointer, wrapping.
    always_comb begin
        int idx;
        found   = 1'b0;
        sel_idx = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && REQ[idx]) begin
                found   = 1'b1;
                sel_idx = PTR_W'(idx);
            end
        end
    end

    // Write strobes are purely combinational on the registered state, so an
    // asynchronous reset (which forces state to IDLE) silences them at once.
    assign w_inc     = (state == BURST) && !FULL;
    assign last_beat = w_inc && (cnt == CNT_W'(PKT_LEN - 1));
    assign beat_data = REQ_DATA[int'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];

    assign W_INC   = w_inc;
    assign POP     = gnt & {N_REQ{w_inc}};
    assign GNT     = gnt;
    assign BUSY    = (state == BURST);
    assign WR_DATA = (state == BURST) ? beat_data : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= gnt_idx_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        gnt_idx_nxt = gnt_idx;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt     = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    gnt_idx_nxt = sel_idx;
                    cnt_nxt     = '0;
                    state_nxt   = BURST;
                end
            end
            BURST: begin
                if (last_beat) begin
                    // Grant is held through any FULL stall on the final beat;
                    // it drops only once that beat is actually written.
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    ptr_nxt   = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
                    state_nxt = IDLE;
                end else if (w_inc) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] stall_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pkt_cnt   <= 16'h0000;
            stall_cnt <= 16'h0000;
        end else begin
            if (last_beat) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if ((state == BURST) && FULL && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign PKT_CNT   = pkt_cnt;
    assign STALL_CNT = stall_cnt;
`else
    assign PKT_CNT   = 16'h0000;
    assign STALL_CNT = 16'h0000;
`endif

endmodule
